// File: rtl/pe_tile_sequencer.sv
// Walks one matrix tile through the PE array: weight-tile fetch, activation-row
// stream, systolic drain, then a one-cycle done. Owns the buffer read port while busy.
module pe_tile_sequencer #(
    parameter int ARRAY_SIZE             = 8,
    parameter int COMPUTE_DATA_WIDTH     = 4,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int BUFFER_WORD_SIZE       = 16,
    parameter int NUM_COMPUTE_LANES      = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
    parameter int PE_LATENCY             = 3,
    parameter int ADDR_WIDTH             = 10,
    parameter int ROW_CNT_WIDTH          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       w_base_addr,
    input  logic [ADDR_WIDTH-1:0]       a_base_addr,
    input  logic [ROW_CNT_WIDTH-1:0]    num_rows,
    output logic                        busy,
    output logic                        done,
    output logic                        buf_rd_en,
    output logic [ADDR_WIDTH-1:0]       buf_rd_addr,
    input  logic [BUFFER_WORD_SIZE-1:0] buf_rd_data,
    output logic                        pe_load_en,
    output logic                        pe_act_valid,
    output logic [ADDR_WIDTH-1:0]       pe_idx,
    output logic [BUFFER_WORD_SIZE-1:0] pe_data,
    output logic                        pe_compute
);

    localparam int WW    = ARRAY_SIZE * ARRAY_SIZE / NUM_COMPUTE_LANES;
    localparam int RW    = ARRAY_SIZE / NUM_COMPUTE_LANES;
    localparam int DRAIN = PE_LATENCY + 2 * ARRAY_SIZE - 1;

    // One counter serves all three phases, so size it for the largest of them.
    localparam int CNT_A = ROW_CNT_WIDTH + $clog2(RW) + 1;
    localparam int CNT_B = $clog2(WW) + 1;
    localparam int CNT_C = $clog2(DRAIN) + 1;
    localparam int CNT_AB = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CNT_W  = (CNT_AB > CNT_C) ? CNT_AB : CNT_C;

    generate
        if (ACCUMULATOR_DATA_WIDTH < 2 * COMPUTE_DATA_WIDTH) begin : g_acc_width_check
            $error("ACCUMULATOR_DATA_WIDTH cannot hold a single operand product");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]        stream_words_q, stream_words_d;
    logic [ADDR_WIDTH-1:0]   w_base_q, w_base_d;
    logic [ADDR_WIDTH-1:0]   a_base_q, a_base_d;

    // Return-path tag: describes the word arriving on buf_rd_data this cycle.
    logic                    tag_valid_q, tag_valid_d;
    logic                    tag_is_w_q, tag_is_w_d;
    logic [ADDR_WIDTH-1:0]   tag_idx_q, tag_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            stream_words_q <= '0;
            w_base_q       <= '0;
            a_base_q       <= '0;
            tag_valid_q    <= 1'b0;
            tag_is_w_q     <= 1'b0;
            tag_idx_q      <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            stream_words_q <= stream_words_d;
            w_base_q       <= w_base_d;
            a_base_q       <= a_base_d;
            tag_valid_q    <= tag_valid_d;
            tag_is_w_q     <= tag_is_w_d;
            tag_idx_q      <= tag_idx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        stream_words_d = stream_words_q;
        w_base_d       = w_base_q;
        a_base_d       = a_base_q;
        busy           = (state_q != S_IDLE);
        done           = 1'b0;
        buf_rd_en      = 1'b0;
        buf_rd_addr    = '0;
        pe_compute     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_base_d       = w_base_addr;
                    a_base_d       = a_base_addr;
                    stream_words_d = CNT_W'(num_rows) * CNT_W'(RW);
                    k_d            = '0;
                    state_d        = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                buf_rd_en   = 1'b1;
                buf_rd_addr = w_base_q + ADDR_WIDTH'(k_q);
                if (k_q == CNT_W'(WW - 1)) begin
                    k_d     = '0;
                    state_d = (stream_words_q == '0) ? S_DONE : S_STREAM;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                buf_rd_en   = 1'b1;
                buf_rd_addr = a_base_q + ADDR_WIDTH'(k_q);
                pe_compute  = 1'b1;
                if (k_q == stream_words_q - CNT_W'(1)) begin
                    k_d     = CNT_W'(DRAIN - 1);
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                pe_compute = 1'b1;
                if (k_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        tag_valid_d = buf_rd_en;
        tag_is_w_d  = (state_q == S_LOAD_W);
        tag_idx_d   = buf_rd_en ? ADDR_WIDTH'(k_q) : '0;
    end

    assign pe_load_en   = tag_valid_q & tag_is_w_q;
    assign pe_act_valid = tag_valid_q & ~tag_is_w_q;
    assign pe_idx       = tag_idx_q;

    // Lanes pass through untouched; gated to zero when no read is landing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COMPUTE_LANES; gi++) begin : g_lane
            assign pe_data[gi*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] =
                tag_valid_q ? buf_rd_data[gi*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH]
                            : '0;
        end
    endgenerate

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Directed bench for pe_tile_sequencer: buffer model returns data=addr, and a
// scoreboard queue predicts each word landing on the PE side one cycle after its read.
module tb_pe_tile_sequencer;

    localparam int AW  = 10;
    localparam int RCW = 8;
    localparam int BW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] w_base_addr;
    logic [AW-1:0] a_base_addr;
    logic [RCW-1:0] num_rows;
    logic          busy;
    logic          done;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [BW-1:0] buf_rd_data;
    logic          pe_load_en;
    logic          pe_act_valid;
    logic [AW-1:0] pe_idx;
    logic [BW-1:0] pe_data;
    logic          pe_compute;

    pe_tile_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .w_base_addr  (w_base_addr),
        .a_base_addr  (a_base_addr),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .pe_load_en   (pe_load_en),
        .pe_act_valid (pe_act_valid),
        .pe_idx       (pe_idx),
        .pe_data      (pe_data),
        .pe_compute   (pe_compute)
    );

    always #5 clk = ~clk;

    // Buffer model: one-cycle read latency, word content equals its address.
    always @(posedge clk) begin
        buf_rd_data <= buf_rd_en ? BW'(buf_rd_addr) : '0;
    end

    typedef struct {
        logic          is_w;
        logic [AW-1:0] idx;
        logic [BW-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".busy"},       32'(busy),       32'd0);
        chk({tag, ".done"},       32'(done),       32'd0);
        chk({tag, ".buf_rd_en"},  32'(buf_rd_en),  32'd0);
        chk({tag, ".pe_compute"}, 32'(pe_compute), 32'd0);
        chk({tag, ".pe_load"},    32'(pe_load_en), 32'd0);
        chk({tag, ".pe_act"},     32'(pe_act_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        chk({tag, ".buf_rd_addr"}, 32'(buf_rd_addr), 32'd0);
        chk({tag, ".pe_idx"},      32'(pe_idx),      32'd0);
        chk({tag, ".pe_data"},     32'(pe_data),     32'd0);
    endtask

    // Runs one tile; pulse_c/pulse_d raise start during that cycle (must be ignored),
    // abort_c asserts rst during that cycle and checks the tile dies silently.
    task automatic run_tile(input logic [AW-1:0] w, input logic [AW-1:0] a,
                            input logic [RCW-1:0] n, input int pulse_c,
                            input int pulse_d, input int abort_c);
        int            sw;
        int            total;
        logic          exp_rd;
        logic          exp_cmp;
        logic [AW-1:0] ea;
        exp_t          e;
        exp_t          p;

        sw    = int'(n) * 2;
        total = (n == 0) ? 17 : 16 + sw + 18 + 1;
        $display("tile: w_base=0x%0h a_base=0x%0h num_rows=%0d", w, a, n);

        w_base_addr = w;
        a_base_addr = a;
        num_rows    = n;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        w_base_addr = ~w;
        a_base_addr = ~a;
        num_rows    = n + 8'd5;

        for (int c = 1; c <= total; c++) begin
            exp_rd  = (c <= 16 + sw);
            exp_cmp = (n != 0) && (c >= 17) && (c <= 16 + sw + 18);
            ea      = (c <= 16) ? w + AW'(c - 1) : a + AW'(c - 17);

            chk($sformatf("c%0d.busy", c),       32'(busy),       32'd1);
            chk($sformatf("c%0d.done", c),       32'(done),       32'(c == total));
            chk($sformatf("c%0d.buf_rd_en", c),  32'(buf_rd_en),  32'(exp_rd));
            chk($sformatf("c%0d.pe_compute", c), 32'(pe_compute), 32'(exp_cmp));
            if (exp_rd) begin
                chk($sformatf("c%0d.buf_rd_addr", c), 32'(buf_rd_addr), 32'(ea));
            end

            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("c%0d.pe_load_en", c),   32'(pe_load_en),   32'(e.is_w));
                chk($sformatf("c%0d.pe_act_valid", c), 32'(pe_act_valid), 32'(!e.is_w));
                chk($sformatf("c%0d.pe_idx", c),       32'(pe_idx),       32'(e.idx));
                chk($sformatf("c%0d.pe_data", c),      32'(pe_data),      32'(e.data));
                $display("  txn c%0d %s idx=%0d data=0x%0h", c, e.is_w ? "W" : "A", pe_idx, pe_data);
            end else begin
                chk($sformatf("c%0d.pe_load_en", c),   32'(pe_load_en),   32'd0);
                chk($sformatf("c%0d.pe_act_valid", c), 32'(pe_act_valid), 32'd0);
            end

            if (exp_rd) begin
                p.is_w = (c <= 16);
                p.idx  = (c <= 16) ? AW'(c - 1) : AW'(c - 17);
                p.data = BW'(ea);
                sbq.push_back(p);
            end

            start = (c == pulse_c) || (c == pulse_d);

            if (c == abort_c) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_all_zero($sformatf("abort_c%0d", c));
                rst   = 1'b0;
                start = 1'b0;
                sbq.delete();
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    check_idle($sformatf("post_abort%0d", i));
                end
                $display("tile aborted by rst at cycle %0d", c);
                return;
            end

            @(posedge clk); #1;
        end

        start = 1'b0;
        check_idle("after_done");
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        @(posedge clk); #1;
        check_idle("after_done+1");
        $display("tile complete: %0d cycles", total);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        w_base_addr = '0;
        a_base_addr = '0;
        num_rows    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("idle%0d", i));
        end

        // Main tile; extra starts at cycle 5 and in DONE (cycle 43) must be ignored.
        run_tile(10'h100, 10'h200, 8'd4, 5, 43, 0);
        // Zero rows: weights only, no compute.
        run_tile(10'h050, 10'h060, 8'd0, 0, 0, 0);
        // Both weight and activation addresses wrap past 0x3FF.
        run_tile(10'h3F8, 10'h3FC, 8'd3, 0, 0, 0);
        // Reset at cycle 10 of a tile aborts it.
        run_tile(10'h010, 10'h020, 8'd2, 0, 0, 10);
        // Sequencer recovers cleanly after the abort.
        run_tile(10'h0A0, 10'h0B0, 8'd1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
